debug_sel_scanner: RTL
======================

# debug_sel_scanner

Automatic scanner for the system's debug display path. On a start pulse it steps `SYS_output_sel` through every selector, waits a fixed settle time, and captures the `SYS_leds` word for each selector. Each capture is presented on a valid/ready stream for a downstream consumer such as a serial dumper or a bench monitor. It sits beside `system`, in place of manual selector switches, and drives the selector that the board or testbench would otherwise drive.

## Interface
- `NUM_SEL`, 8: selectors scanned, 0..NUM_SEL-1; power of two, ≤ 2^SEL_W
- `SEL_W`, 3: selector width
- `DATA_W`, 27: captured LED word width
- `SETTLE`, 2: cycles the selector is held before capture; must be ≥1

Ports:
- `clk` in 1: system clock, rising edge
- `SYS_reset_n` in 1: asynchronous, active-low reset
- `start` in 1: begin scan; sampled in IDLE only
- `abort` in 1: synchronous cancel; priority over everything except reset
- `SYS_output_sel` out SEL_W: selector driven to `system`
- `SYS_leds` in DATA_W: debug word from `system`
- `out_valid` out 1: capture available
- `out_ready` in 1: consumer accepts
- `out_sel` out SEL_W: selector the capture belongs to
- `out_data` out DATA_W: captured LED word
- `busy` out 1: scan in progress
- `done` out 1: one-cycle pulse on scan completion

## Operation
- Reset (async, SYS_reset_n=0):
  - state IDLE
  - SYS_output_sel=0, out_valid=0, out_sel=0, out_data=0, busy=0, done=0
  - settle counter = 0
- FSM states IDLE, WAIT, SEND; all outputs registered.
- IDLE:
  - If start=1 and abort=0: SYS_output_sel←0, cnt←SETTLE-1, busy←1, go to WAIT.
  - Otherwise hold.
- WAIT:
  - If cnt≠0: cnt←cnt-1.
  - If cnt=0: out_data←SYS_leds, out_sel←SYS_output_sel, out_valid←1, go to SEND.
- SEND:
  - Hold out_valid, out_data and out_sel stable until the handshake (out_valid & out_ready at a rising edge).
  - On handshake with SYS_output_sel<NUM_SEL-1: out_valid←0, SYS_output_sel←SYS_output_sel+1, cnt←SETTLE-1, go to WAIT.
  - On handshake with SYS_output_sel=NUM_SEL-1: out_valid←0, busy←0, done←1, SYS_output_sel←0, go to IDLE.
- abort=1 in WAIT or SEND:
  - Go to IDLE; out_valid←0, busy←0, SYS_output_sel←0.
  - done stays 0. out_data and out_sel keep their last values.
  - An in-flight handshake in the same cycle is discarded; the consumer must ignore it.
- start while busy is ignored. start and abort together in IDLE: abort wins and the block stays IDLE.
- done is cleared the cycle after it is set.
- Selector increment never wraps past NUM_SEL-1; completion is detected before the increment.

## Timing
- start sampled high at edge k:
  - SYS_output_sel=0 and busy=1 after edge k.
  - Capture at edge k+SETTLE; out_valid=1 after that edge.
  - SYS_leds is sampled after the selector has been stable for exactly SETTLE cycles.
- Per selector, with out_ready held high: SETTLE+1 cycles from selector change to handshake edge.
- Full scan, out_ready=1 throughout: final handshake at edge k+NUM_SEL·(SETTLE+1). done is high for the following cycle and busy is low from then on.
- Back-pressure: each cycle out_ready=0 in SEND adds one cycle. Data never changes while out_valid=1.
- New start is accepted at the edge after done is asserted, i.e. the first IDLE cycle.
- Reset asserted mid-scan clears everything immediately (asynchronously). Release resumes in IDLE.

## Test plan
- Defaults; SYS_leds driven as 27'h100_0000+sel; start pulse; out_ready=1.
  - 8 beats, out_sel 0..7 with matching data.
  - done at edge k+24; busy high for 24 cycles; SYS_output_sel returns to 0.
- Back-pressure: out_ready low for 5 cycles on beat 3.
  - out_valid/out_data/out_sel stable throughout.
  - Scan completes 5 cycles later (edge k+29).
- Settle check: SYS_leds changes only 2 cycles after each selector change (stale value earlier).
  - Every captured word equals the post-change value, never the stale one.
- abort during SEND of beat 4 with out_ready=1 in the same cycle.
  - IDLE next cycle; out_valid=0, busy=0, done never pulses, SYS_output_sel=0.
- start held high continuously across a scan.
  - Second scan begins in the first IDLE cycle after done. No start accepted while busy.
- SYS_reset_n pulsed low during WAIT of beat 2.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, no activity until the next start.

Source files
------------

// File: rtl/debug_sel_scanner.sv
// Steps the debug selector through every value, waits SETTLE cycles for the
// LED word to follow, and offers each capture on a valid/ready stream.
module debug_sel_scanner #(
  parameter int NUM_SEL = 8,
  parameter int SEL_W   = 3,
  parameter int DATA_W  = 27,
  parameter int SETTLE  = 2
) (
  input  logic              clk,
  input  logic              SYS_reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  SYS_output_sel,
  input  logic [DATA_W-1:0] SYS_leds,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SEL - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_d, out_sel_d;
  logic [DATA_W-1:0] out_data_d;
  logic              valid_d, busy_d, done_d;
  logic              handshake;

  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = WAIT;
        WAIT:    if (cnt_q == '0) state_d = SEND;
        SEND:    if (handshake) state_d = (SYS_output_sel == LAST_SEL) ? IDLE : WAIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of every registered output; done defaults low so it pulses.
  always_comb begin
    sel_d      = SYS_output_sel;
    cnt_d      = cnt_q;
    out_sel_d  = out_sel;
    out_data_d = out_data;
    valid_d    = out_valid;
    busy_d     = busy;
    done_d     = 1'b0;
    if (abort) begin
      // Any handshake in this cycle is dropped; captured data is left as is.
      valid_d = 1'b0;
      busy_d  = 1'b0;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_d  = '0;
            cnt_d  = CNT_LOAD;
            busy_d = 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            out_data_d = SYS_leds;
            out_sel_d  = SYS_output_sel;
            valid_d    = 1'b1;
          end
        end
        SEND: begin
          if (handshake) begin
            valid_d = 1'b0;
            if (SYS_output_sel == LAST_SEL) begin
              busy_d = 1'b0;
              done_d = 1'b1;
              sel_d  = '0;
            end else begin
              sel_d = SYS_output_sel + 1'b1;
              cnt_d = CNT_LOAD;
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          sel_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      SYS_output_sel <= '0;
      cnt_q          <= '0;
      out_sel        <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      SYS_output_sel <= sel_d;
      cnt_q          <= cnt_d;
      out_sel        <= out_sel_d;
      out_data       <= out_data_d;
      out_valid      <= valid_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

endmodule
